// File: rtl/axi_rd_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_wr_arbiter
//
// Purpose:
//   Shares the single CPU AXI3 master port between the icache (read-only) and
//   the dcache AXI engine (read + write). One requester owns AR/R from the
//   moment its request is accepted until the rlast beat comes back. The write
//   channels belong to the dcache alone and are passed straight through. The
//   arbiter tracks the one outstanding write so that a read of the same cache
//   line cannot overtake it (read-after-write hazard).
//
// Configuration:
//   ARB_RR_EN  defined   : round-robin between icache and dcache on a tie;
//                          the requester granted last loses the tie.
//              undefined : fixed priority, dcache always beats icache.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   i_ar*, i_r*              icache read request / read data return
//   d_ar*, d_r*              dcache read request / read data return
//   d_aw*, d_w*, d_b*        dcache write channels (pass-through)
//   m_ar*, m_r*              master read address / read data channels
//   m_aw*, m_w*, m_b*        master write channels (awid = wid = DCACHE_ID)
//   rd_err                   sticky: bad rlast beat count or unexpected rid
// -----------------------------------------------------------------------------
module axi_rd_wr_arbiter #(
    parameter int         LINE_OFF_W = 6,
    parameter logic [3:0] ICACHE_ID  = 4'd0,
    parameter logic [3:0] DCACHE_ID  = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    // icache read side
    input  logic        i_arvalid,
    output logic        i_arready,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    output logic [31:0] i_rdata,
    output logic [1:0]  i_rresp,
    output logic        i_rvalid,
    output logic        i_rlast,
    // dcache read side
    input  logic        d_arvalid,
    output logic        d_arready,
    input  logic [31:0] d_araddr,
    input  logic [3:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    output logic [31:0] d_rdata,
    output logic [1:0]  d_rresp,
    output logic        d_rvalid,
    output logic        d_rlast,
    // dcache write side
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_awaddr,
    input  logic [3:0]  d_awlen,
    input  logic [2:0]  d_awsize,
    input  logic        d_wvalid,
    output logic        d_wready,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wlast,
    output logic        d_bvalid,
    output logic [1:0]  d_bresp,
    output logic [3:0]  d_bid,
    // master read address
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic [1:0]  m_arlock,
    output logic [3:0]  m_arcache,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    // master read data
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    // master write address
    output logic [3:0]  m_awid,
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic [1:0]  m_awlock,
    output logic [3:0]  m_awcache,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    // master write data
    output logic [3:0]  m_wid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    // master write response
    input  logic [3:0]  m_bid,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    // status
    output logic        rd_err
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rdState_t;

    rdState_t              state_q;
    logic                  ownerD_q;
    logic [3:0]            arId_q;
    logic [31:0]           arAddr_q;
    logic [3:0]            arLen_q;
    logic [2:0]            arSize_q;
    logic                  arValid_q;
    logic [3:0]            beatCnt_q;
    logic                  rdErr_q;
    logic                  wrPend_q;
    logic [31:LINE_OFF_W]  wrLine_q;
`ifdef ARB_RR_EN
    logic                  lastGrantD_q;
`endif

    logic awFire;
    logic iHazard;
    logic dHazard;
    logic grantI_d;
    logic grantD_d;
    logic iSel;
    logic dSel;

    // Write channels are owned by the dcache and pass straight through. Only one
    // write may be outstanding, so the AW handshake is blocked while one is pending.
    assign m_awid    = DCACHE_ID;
    assign m_awaddr  = d_awaddr;
    assign m_awlen   = d_awlen;
    assign m_awsize  = d_awsize;
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'b0000;
    assign m_awprot  = 3'b000;
    assign m_awvalid = d_awvalid & ~wrPend_q;
    assign d_awready = m_awready & ~wrPend_q;
    assign m_wid     = DCACHE_ID;
    assign m_wdata   = d_wdata;
    assign m_wstrb   = d_wstrb;
    assign m_wlast   = d_wlast;
    assign m_wvalid  = d_wvalid;
    assign d_wready  = m_wready;
    assign d_bvalid  = m_bvalid;
    assign d_bresp   = m_bresp;
    assign d_bid     = m_bid;
    assign m_bready  = 1'b1;
    assign m_rready  = 1'b1;

    assign awFire = m_awvalid & m_awready;

    // A read to the line of the pending write must wait for the write response.
    // The AW address bus is also compared so that a write accepted in this very
    // cycle already blocks a read of its line.
    assign iHazard = (wrPend_q & (i_araddr[31:LINE_OFF_W] == wrLine_q)) |
                     (awFire   & (i_araddr[31:LINE_OFF_W] == d_awaddr[31:LINE_OFF_W]));
    assign dHazard = (wrPend_q & (d_araddr[31:LINE_OFF_W] == wrLine_q)) |
                     (awFire   & (d_araddr[31:LINE_OFF_W] == d_awaddr[31:LINE_OFF_W]));

    // Grant decision, only taken while the read channel is idle. A tie goes to the
    // dcache, or with round-robin enabled to whoever was not granted last.
    always_comb begin
        grantI_d = 1'b0;
        grantD_d = 1'b0;
        if (state_q == R_IDLE) begin
            if ((i_arvalid & ~iHazard) && (d_arvalid & ~dHazard)) begin
`ifdef ARB_RR_EN
                if (lastGrantD_q) begin
                    grantI_d = 1'b1;
                end else begin
                    grantD_d = 1'b1;
                end
`else
                grantD_d = 1'b1;
`endif
            end else if (d_arvalid & ~dHazard) begin
                grantD_d = 1'b1;
            end else if (i_arvalid & ~iHazard) begin
                grantI_d = 1'b1;
            end
        end
    end

    assign i_arready = grantI_d;
    assign d_arready = grantD_d;

    // Read data is steered only to the current owner; the other side sees zeros.
    assign iSel     = (state_q == R_DATA) & ~ownerD_q;
    assign dSel     = (state_q == R_DATA) &  ownerD_q;
    assign i_rvalid = iSel & m_rvalid;
    assign i_rlast  = iSel & m_rvalid & m_rlast;
    assign i_rdata  = iSel ? m_rdata : 32'h0;
    assign i_rresp  = iSel ? m_rresp : 2'b00;
    assign d_rvalid = dSel & m_rvalid;
    assign d_rlast  = dSel & m_rvalid & m_rlast;
    assign d_rdata  = dSel ? m_rdata : 32'h0;
    assign d_rresp  = dSel ? m_rresp : 2'b00;

    assign m_arid    = arId_q;
    assign m_araddr  = arAddr_q;
    assign m_arlen   = arLen_q;
    assign m_arsize  = arSize_q;
    assign m_arburst = 2'b01;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'b0000;
    assign m_arprot  = 3'b000;
    assign m_arvalid = arValid_q;
    assign rd_err    = rdErr_q;

    // Read FSM plus write tracking. The request fields are latched at grant and
    // held on AR until the slave accepts them. The beat counter holds the number
    // of beats already seen, so at the rlast beat it must equal arlen.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= R_IDLE;
            ownerD_q  <= 1'b0;
            arId_q    <= 4'h0;
            arAddr_q  <= 32'h0;
            arLen_q   <= 4'h0;
            arSize_q  <= 3'h0;
            arValid_q <= 1'b0;
            beatCnt_q <= 4'h0;
            rdErr_q   <= 1'b0;
            wrPend_q  <= 1'b0;
            wrLine_q  <= '0;
`ifdef ARB_RR_EN
            lastGrantD_q <= 1'b0;
`endif
        end else begin
            if (awFire) begin
                wrPend_q <= 1'b1;
                wrLine_q <= d_awaddr[31:LINE_OFF_W];
            end else if (m_bvalid) begin
                wrPend_q <= 1'b0;
            end

            case (state_q)
                R_IDLE: begin
                    if (grantI_d || grantD_d) begin
                        state_q   <= R_ADDR;
                        arValid_q <= 1'b1;
                        ownerD_q  <= grantD_d;
                        arId_q    <= grantD_d ? DCACHE_ID : ICACHE_ID;
                        arAddr_q  <= grantD_d ? d_araddr : i_araddr;
                        arLen_q   <= grantD_d ? d_arlen  : i_arlen;
                        arSize_q  <= grantD_d ? d_arsize : i_arsize;
                        beatCnt_q <= 4'h0;
`ifdef ARB_RR_EN
                        lastGrantD_q <= grantD_d;
`endif
                    end
                end
                R_ADDR: begin
                    if (m_arready) begin
                        arValid_q <= 1'b0;
                        state_q   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (m_rvalid) begin
                        if (m_rid != arId_q) begin
                            rdErr_q <= 1'b1;
                        end
                        if (m_rlast) begin
                            if (beatCnt_q != arLen_q) begin
                                rdErr_q <= 1'b1;
                            end
                            beatCnt_q <= 4'h0;
                            state_q   <= R_IDLE;
                        end else begin
                            beatCnt_q <= beatCnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_wr_arbiter
//
// Directed bench for axi_rd_wr_arbiter. The slave side of the master port is
// driven by hand, step by step, and every expected value is a hand-computed
// constant. Inputs change 1 ns after the rising edge and outputs are sampled
// 1 ns later, well away from the edge. Honors ARB_RR_EN for the tie cases.
// -----------------------------------------------------------------------------
module tb_axi_rd_wr_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        i_arvalid, i_arready;
    logic [31:0] i_araddr;
    logic [3:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid, i_rlast;
    logic        d_arvalid, d_arready;
    logic [31:0] d_araddr;
    logic [3:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic [31:0] d_rdata;
    logic [1:0]  d_rresp;
    logic        d_rvalid, d_rlast;
    logic        d_awvalid, d_awready;
    logic [31:0] d_awaddr;
    logic [3:0]  d_awlen;
    logic [2:0]  d_awsize;
    logic        d_wvalid, d_wready;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_wlast;
    logic        d_bvalid;
    logic [1:0]  d_bresp;
    logic [3:0]  d_bid;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [3:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_arlock;
    logic [3:0]  m_arcache;
    logic [2:0]  m_arprot;
    logic        m_arvalid, m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast, m_rvalid, m_rready;
    logic [3:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst, m_awlock;
    logic [3:0]  m_awcache;
    logic [2:0]  m_awprot;
    logic        m_awvalid, m_awready;
    logic [3:0]  m_wid;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [3:0]  m_bid;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic        rd_err;

    int checks   = 0;
    int failures = 0;
    bit winD;

    axi_rd_wr_arbiter #(
        .LINE_OFF_W (6),
        .ICACHE_ID  (4'd0),
        .DCACHE_ID  (4'd1)
    ) dut (
        .aclk      (aclk),      .aresetn   (aresetn),
        .i_arvalid (i_arvalid), .i_arready (i_arready), .i_araddr (i_araddr),
        .i_arlen   (i_arlen),   .i_arsize  (i_arsize),  .i_rdata  (i_rdata),
        .i_rresp   (i_rresp),   .i_rvalid  (i_rvalid),  .i_rlast  (i_rlast),
        .d_arvalid (d_arvalid), .d_arready (d_arready), .d_araddr (d_araddr),
        .d_arlen   (d_arlen),   .d_arsize  (d_arsize),  .d_rdata  (d_rdata),
        .d_rresp   (d_rresp),   .d_rvalid  (d_rvalid),  .d_rlast  (d_rlast),
        .d_awvalid (d_awvalid), .d_awready (d_awready), .d_awaddr (d_awaddr),
        .d_awlen   (d_awlen),   .d_awsize  (d_awsize),
        .d_wvalid  (d_wvalid),  .d_wready  (d_wready),  .d_wdata  (d_wdata),
        .d_wstrb   (d_wstrb),   .d_wlast   (d_wlast),
        .d_bvalid  (d_bvalid),  .d_bresp   (d_bresp),   .d_bid    (d_bid),
        .m_arid    (m_arid),    .m_araddr  (m_araddr),  .m_arlen  (m_arlen),
        .m_arsize  (m_arsize),  .m_arburst (m_arburst), .m_arlock (m_arlock),
        .m_arcache (m_arcache), .m_arprot  (m_arprot),  .m_arvalid(m_arvalid),
        .m_arready (m_arready),
        .m_rid     (m_rid),     .m_rdata   (m_rdata),   .m_rresp  (m_rresp),
        .m_rlast   (m_rlast),   .m_rvalid  (m_rvalid),  .m_rready (m_rready),
        .m_awid    (m_awid),    .m_awaddr  (m_awaddr),  .m_awlen  (m_awlen),
        .m_awsize  (m_awsize),  .m_awburst (m_awburst), .m_awlock (m_awlock),
        .m_awcache (m_awcache), .m_awprot  (m_awprot),  .m_awvalid(m_awvalid),
        .m_awready (m_awready),
        .m_wid     (m_wid),     .m_wdata   (m_wdata),   .m_wstrb  (m_wstrb),
        .m_wlast   (m_wlast),   .m_wvalid  (m_wvalid),  .m_wready (m_wready),
        .m_bid     (m_bid),     .m_bresp   (m_bresp),   .m_bvalid (m_bvalid),
        .m_bready  (m_bready),
        .rd_err    (rd_err)
    );

    // Free-running 100 MHz clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Safety net so the run always ends even if the stimulus gets stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // One comparison: counts it, and on a miss counts and reports the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a read request on the icache (isD=0) or dcache (isD=1) side
    task automatic applyStimulus(input bit isD, input bit valid,
                                 input logic [31:0] addr, input logic [3:0] len);
        if (isD) begin
            d_arvalid = valid; d_araddr = addr; d_arlen = len; d_arsize = 3'd2;
        end else begin
            i_arvalid = valid; i_araddr = addr; i_arlen = len; i_arsize = 3'd2;
        end
    endtask

    // Slave returns a burst; steering to the owner is checked on every beat
    task automatic runBurst(input string tag, input logic [3:0] rid, input int beats,
                            input bit isD, input bit endLast);
        for (int k = 0; k < beats; k++) begin
            m_rvalid = 1'b1;
            m_rid    = rid;
            m_rdata  = 32'hA000_0000 + k;
            m_rlast  = endLast && (k == beats - 1);
            #1;
            checkOutput({tag, " own rvalid"},   isD ? d_rvalid : i_rvalid, 1);
            checkOutput({tag, " other rvalid"}, isD ? i_rvalid : d_rvalid, 0);
            checkOutput({tag, " own rlast"},    isD ? d_rlast  : i_rlast,
                        (endLast && (k == beats - 1)) ? 1 : 0);
            if (k == 0) begin
                checkOutput({tag, " own rdata"}, isD ? d_rdata : i_rdata, 32'hA000_0000);
            end
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    // Complete read: grant, AR phase with one cycle of m_arready, full burst
    task automatic fullRead(input string tag, input bit isD,
                            input logic [31:0] addr, input logic [3:0] len);
        applyStimulus(isD, 1'b1, addr, len);
        #1;
        checkOutput({tag, " arready"}, isD ? d_arready : i_arready, 1);
        step();
        applyStimulus(isD, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput({tag, " m_arvalid"}, m_arvalid, 1);
        checkOutput({tag, " m_araddr"},  m_araddr, addr);
        checkOutput({tag, " m_arlen"},   m_arlen, len);
        checkOutput({tag, " m_arid"},    m_arid, isD ? 1 : 0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst(tag, isD ? 4'd1 : 4'd0, int'(len) + 1, isD, 1'b1);
    endtask

    initial begin
        aresetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
        d_awvalid = 0; d_awaddr = 0; d_awlen = 0; d_awsize = 3'd2;
        d_wvalid = 0; d_wdata = 0; d_wstrb = 0; d_wlast = 0;
        m_arready = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bid = 0; m_bresp = 0; m_bvalid = 0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("RST m_arvalid", m_arvalid, 0);
        checkOutput("RST m_araddr",  m_araddr, 0);
        checkOutput("RST i_arready", i_arready, 0);
        checkOutput("RST rd_err",    rd_err, 0);
        checkOutput("RST m_rready",  m_rready, 1);
        checkOutput("RST m_bready",  m_bready, 1);
        aresetn = 1'b1;
        step();

        // T1: icache line fill of 16 beats
        $display("[TB] T1 icache burst");
        fullRead("T1", 1'b0, 32'h1FC0_0000, 4'd15);
        #1;
        checkOutput("T1 rd_err", rd_err, 0);

        // T2: tie -> dcache; icache granted the cycle after the dcache rlast
        $display("[TB] T2 arbitration");
        applyStimulus(1'b0, 1'b1, 32'h0000_3000, 4'd3);
        applyStimulus(1'b1, 1'b1, 32'h0000_4000, 4'd3);
        #1;
        checkOutput("T2 tieA d_arready", d_arready, 1);
        checkOutput("T2 tieA i_arready", i_arready, 0);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("T2 tieA m_arid", m_arid, 1);
        checkOutput("T2 busy i_arready", i_arready, 0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T2 d", 4'd1, 4, 1'b1, 1'b1);
        #1;
        checkOutput("T2 i after rlast", i_arready, 1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("T2 i m_arid",   m_arid, 0);
        checkOutput("T2 i m_araddr", m_araddr, 32'h0000_3000);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T2 i", 4'd0, 4, 1'b0, 1'b1);
        fullRead("T2 dsolo", 1'b1, 32'h0000_4100, 4'd3);

        // Second tie right after a dcache grant
`ifdef ARB_RR_EN
        winD = 1'b0;
`else
        winD = 1'b1;
`endif
        applyStimulus(1'b0, 1'b1, 32'h0000_3100, 4'd1);
        applyStimulus(1'b1, 1'b1, 32'h0000_4200, 4'd1);
        #1;
        checkOutput("T2 tieB grants", {30'h0, i_arready, d_arready}, winD ? 2 'b01 : 2'b10);
        step();
        applyStimulus(winD, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("T2 tieB m_arid", m_arid, winD ? 1 : 0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T2 tieB win", winD ? 4'd1 : 4'd0, 2, winD, 1'b1);
        #1;
        checkOutput("T2 tieB loser", {30'h0, i_arready, d_arready}, winD ? 2'b10 : 2'b01);
        step();
        applyStimulus(!winD, 1'b0, 32'h0, 4'h0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T2 tieB lose", winD ? 4'd0 : 4'd1, 2, !winD, 1'b1);

        // T3: RAW hazard against a pending write
        $display("[TB] T3 read-after-write hazard");
        d_awvalid = 1'b1; d_awaddr = 32'h0000_1040; m_awready = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0000_1060, 4'd0);
        #1;
        checkOutput("T3 aw handshake", d_awready, 1);
        checkOutput("T3 same-cycle i_arready", i_arready, 0);
        step();
        #1;
        checkOutput("T3 second aw blocked", d_awready, 0);
        checkOutput("T3 m_awvalid masked", m_awvalid, 0);
        checkOutput("T3 pend i_arready", i_arready, 0);
        d_awvalid = 1'b0; m_awready = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h0000_2000, 4'd1);
        #1;
        checkOutput("T3 d other line", d_arready, 1);
        checkOutput("T3 i still held", i_arready, 0);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("T3 d m_araddr", m_araddr, 32'h0000_2000);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T3 d", 4'd1, 2, 1'b1, 1'b1);
        #1;
        checkOutput("T3 idle i held", i_arready, 0);
        step();
        m_bvalid = 1'b1;
        #1;
        checkOutput("T3 bvalid cycle i", i_arready, 0);
        checkOutput("T3 d_bvalid", d_bvalid, 1);
        step();
        m_bvalid = 1'b0;
        #1;
        checkOutput("T3 after bvalid i", i_arready, 1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("T3 i m_araddr", m_araddr, 32'h0000_1060);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T3 i", 4'd0, 1, 1'b0, 1'b1);
        #1;
        checkOutput("T3 rd_err", rd_err, 0);

        // T4: AR held while the slave stalls
        $display("[TB] T4 AR backpressure");
        applyStimulus(1'b1, 1'b1, 32'h0000_5000, 4'd7);
        #1;
        checkOutput("T4 d_arready", d_arready, 1);
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("T4 m_arvalid", m_arvalid, 1);
            checkOutput("T4 m_araddr",  m_araddr, 32'h0000_5000);
            checkOutput("T4 m_arlen",   m_arlen, 7);
            checkOutput("T4 no repulse", d_arready, 0);
            step();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        #1;
        checkOutput("T4 arvalid dropped", m_arvalid, 0);
        runBurst("T4 d", 4'd1, 8, 1'b1, 1'b1);
        #1;
        checkOutput("T4 rd_err", rd_err, 0);

        // T5: early rlast sets the sticky error and ends the burst
        $display("[TB] T5 early rlast");
        applyStimulus(1'b0, 1'b1, 32'h0000_6000, 4'd15);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T5 i", 4'd0, 3, 1'b0, 1'b1);
        #1;
        checkOutput("T5 rd_err set", rd_err, 1);
        step();
        #1;
        checkOutput("T5 rd_err sticky", rd_err, 1);

        // T6: reset in the middle of a burst with a write pending
        $display("[TB] T6 reset mid-burst");
        d_awvalid = 1'b1; d_awaddr = 32'h0000_8000; m_awready = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0000_9000, 4'd15);
        #1;
        checkOutput("T6 back to idle", d_arready, 1);
        step();
        d_awvalid = 1'b0; m_awready = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T6 d", 4'd1, 6, 1'b1, 1'b0);
        m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b0;
        aresetn = 1'b0;
        #1;
        checkOutput("T6 d_rvalid", d_rvalid, 0);
        checkOutput("T6 rd_err",   rd_err, 0);
        checkOutput("T6 m_arvalid", m_arvalid, 0);
        checkOutput("T6 m_arid",   m_arid, 0);
        checkOutput("T6 m_rready", m_rready, 1);
        step();
        aresetn = 1'b1;
        m_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0000_8000, 4'd0);
        #1;
        checkOutput("T6 wr_pend cleared", i_arready, 1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T6 i", 4'd0, 1, 1'b0, 1'b1);
        #1;
        checkOutput("T6 rd_err clean", rd_err, 0);

        // T7: wrong rid on a correctly sized burst
        $display("[TB] T7 rid mismatch");
        applyStimulus(1'b1, 1'b1, 32'h0000_A000, 4'd0);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        runBurst("T7 d", 4'd0, 1, 1'b1, 1'b1);
        #1;
        checkOutput("T7 rd_err", rd_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
